reg_file_sequencer: RTL and testbench
=====================================

REG_FILE_SEQUENCER -- requirements
Module: reg_file_sequencer

Interface
REQ-001 SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 INSTR_VALID  input  1  decoded instruction offered.
REQ-005 INSTR_READY  output  1  sequencer can accept an instruction.
REQ-006 RS1, RS2, RD  input  5 each  decoded register indices.
REQ-007 USE_RS1, USE_RS2, USE_RD  input  1 each  instruction reads rs1 / reads rs2 / writes rd.
REQ-008 LINK  input  1  writeback value is PC+4 (JAL/JALR), not the execute result.
REQ-009 EXE_START  output  1  one-cycle pulse: operands valid, execute may begin.
REQ-010 EXE_DONE  input  1  execute result valid.
REQ-011 REG_READ_Ctrl_1, REG_READ_Ctrl_2  output  1 each  read-port enables (0 selects x0).
REQ-012 Reg_Addr_1, Reg_Addr_2  output  5 each  read-port indices.
REQ-013 WRITE_EN  output  1  register-file write strobe.
REQ-014 WRITE_Addr  output  5  write index.
REQ-015 REG_WRITE_Ctrl  output  1  write-data select: 1 = PC+4, 0 = execute result.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 RETIRE_CNT  output  16  count of retired instructions.

Function
REQ-018 FSM states SHALL be IDLE, READ, EXEC, WB.
REQ-019 IDLE: INSTR_READY=1; on INSTR_VALID=1, RS1/RS2/RD/USE_*/LINK latch at the clock edge and the FSM moves to READ.
REQ-020 INSTR_READY SHALL be 0 in READ, EXEC and WB; INSTR_VALID there is ignored and nothing is latched.
REQ-021 READ lasts exactly one cycle: EXE_START=1; the FSM then moves to EXEC.
REQ-022 In READ and EXEC: REG_READ_Ctrl_1 = latched USE_RS1; Reg_Addr_1 = latched RS1 when USE_RS1=1, else 0. Port 2 is identical using USE_RS2/RS2.
REQ-023 In IDLE and WB, both read enables and both read addresses SHALL be 0.
REQ-024 EXEC holds until EXE_DONE=1. EXE_DONE is sampled only in EXEC and ignored in all other states.
REQ-025 On EXE_DONE in EXEC: if latched USE_RD=1 and RD!=0, go to WB; otherwise retire and go to IDLE.
REQ-026 WB lasts exactly one cycle: WRITE_EN=1, WRITE_Addr=latched RD, REG_WRITE_Ctrl=latched LINK; the FSM then returns to IDLE and retires.
REQ-027 Outside WB: WRITE_EN=0, WRITE_Addr=0, REG_WRITE_Ctrl=0. Writes to x0 SHALL never be issued.
REQ-028 Retire: RETIRE_CNT increments by 1 on the transition into IDLE from EXEC or WB; it wraps from 0xFFFF to 0x0000.
REQ-029 Latency from the accept edge (cycle 0), with EXE_DONE in the first EXEC cycle:
 - READ in cycle 1, EXEC in cycle 2, WB in cycle 3, IDLE in cycle 4.
 - Minimum issue interval is 4 cycles with writeback, 3 without.
REQ-030 All outputs SHALL be decoded from registered state and latched fields only; there is no combinational input-to-output path except none.

Reset
REQ-031 While RST=1 (asserted asynchronously), the FSM SHALL be in IDLE, RETIRE_CNT=0, latched fields=0, and every output=0 except INSTR_READY, which SHALL be 1 after reset release.
REQ-032 Reset asserted in any state SHALL abort the instruction: no WRITE_EN pulse, no EXE_START, and no retire count.

Verification
REQ-033 Reset, then ADD x5,x1,x2 (USE_RS1/RS2/RD=1, LINK=0), EXE_DONE in cycle 2 -> cycle 1 EXE_START=1, Addr1=1, Addr2=2; cycle 3 WRITE_EN=1, WRITE_Addr=5, REG_WRITE_Ctrl=0; RETIRE_CNT=1.
REQ-034 JAL x1 (USE_RS1/RS2=0, USE_RD=1, LINK=1) -> read enables 0 and addresses 0; WB with WRITE_Addr=1, REG_WRITE_Ctrl=1.
REQ-035 Instruction with RD=0 and USE_RD=1, EXE_DONE after 5 EXEC cycles -> no WRITE_EN; returns to IDLE the cycle after EXE_DONE; RETIRE_CNT increments.
REQ-036 INSTR_VALID held high in EXEC with new fields, plus EXE_DONE pulsed in IDLE -> both ignored; latched fields are unchanged.
REQ-037 RST asserted in EXEC, then released -> IDLE, INSTR_READY=1, RETIRE_CNT=0, no WRITE_EN observed.
REQ-038 Preload 0xFFFF retirements, then retire one more -> RETIRE_CNT=0x0000.

Source files
------------

// File: rtl/reg_file_sequencer.sv
// ---------------------------------------------------------------------------
// reg_file_sequencer
//   Sequences one decoded instruction at a time through register read,
//   execute handshake and register writeback: IDLE -> READ -> EXEC -> WB.
//   Every output is decoded from the registered state and the latched
//   instruction fields, so no input reaches an output combinationally.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   INSTR_VALID/READY instruction offer / accept (accepted only in IDLE)
//   RS1, RS2, RD      decoded register indices
//   USE_RS1/RS2/RD    operand-read and destination-write flags
//   LINK              writeback value is PC+4 rather than execute result
//   EXE_START         one-cycle pulse in READ: operands valid
//   EXE_DONE          execute result valid (sampled only in EXEC)
//   REG_READ_Ctrl_1/2 read-port enables, Reg_Addr_1/2 read-port indices
//   WRITE_EN, WRITE_Addr, REG_WRITE_Ctrl  register-file write strobe,
//                     index and data select (1 = PC+4)
//   BUSY              high whenever not IDLE
//   RETIRE_CNT        wrapping count of retired instructions
// ---------------------------------------------------------------------------
module reg_file_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [4:0]  RS1,
  input  logic [4:0]  RS2,
  input  logic [4:0]  RD,
  input  logic        USE_RS1,
  input  logic        USE_RS2,
  input  logic        USE_RD,
  input  logic        LINK,
  output logic        EXE_START,
  input  logic        EXE_DONE,
  output logic        REG_READ_Ctrl_1,
  output logic        REG_READ_Ctrl_2,
  output logic [4:0]  Reg_Addr_1,
  output logic [4:0]  Reg_Addr_2,
  output logic        WRITE_EN,
  output logic [4:0]  WRITE_Addr,
  output logic        REG_WRITE_Ctrl,
  output logic        BUSY,
  output logic [15:0] RETIRE_CNT
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] EXEC = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic        use_rs1_q, use_rs1_d;
  logic        use_rs2_q, use_rs2_d;
  logic        use_rd_q, use_rd_d;
  logic        link_q, link_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic        accept_s;
  logic        retire_s;
  logic        need_wb_s;

  assign accept_s  = (state_q == IDLE) && INSTR_VALID;
  // x0 is hard-wired zero, so a destination of 0 never earns a WB cycle.
  assign need_wb_s = use_rd_q && (rd_q != 5'd0);

  // Next state, field capture and retire decision.
  always_comb begin
    state_d      = state_q;
    retire_s     = 1'b0;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    use_rs1_d    = use_rs1_q;
    use_rs2_d    = use_rs2_q;
    use_rd_d     = use_rd_q;
    link_d       = link_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = READ;
          rs1_d     = RS1;
          rs2_d     = RS2;
          rd_d      = RD;
          use_rs1_d = USE_RS1;
          use_rs2_d = USE_RS2;
          use_rd_d  = USE_RD;
          link_d    = LINK;
        end else begin
          state_d = IDLE;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        if (EXE_DONE) begin
          if (need_wb_s) begin
            state_d = WB;
          end else begin
            state_d  = IDLE;
            retire_s = 1'b1;
          end
        end else begin
          state_d = EXEC;
        end
      end
      WB: begin
        state_d  = IDLE;
        retire_s = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (retire_s) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end else begin
      retire_cnt_d = retire_cnt_q;
    end
  end

  // State, latched instruction fields and retire counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      rs1_q        <= 5'd0;
      rs2_q        <= 5'd0;
      rd_q         <= 5'd0;
      use_rs1_q    <= 1'b0;
      use_rs2_q    <= 1'b0;
      use_rd_q     <= 1'b0;
      link_q       <= 1'b0;
      retire_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      use_rs1_q    <= use_rs1_d;
      use_rs2_q    <= use_rs2_d;
      use_rd_q     <= use_rd_d;
      link_q       <= link_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Output decode from registered state and latched fields.
  always_comb begin
    INSTR_READY     = 1'b0;
    EXE_START       = 1'b0;
    BUSY            = 1'b1;
    REG_READ_Ctrl_1 = 1'b0;
    REG_READ_Ctrl_2 = 1'b0;
    Reg_Addr_1      = 5'd0;
    Reg_Addr_2      = 5'd0;
    WRITE_EN        = 1'b0;
    WRITE_Addr      = 5'd0;
    REG_WRITE_Ctrl  = 1'b0;
    case (state_q)
      IDLE: begin
        INSTR_READY = 1'b1;
        BUSY        = 1'b0;
      end
      READ, EXEC: begin
        EXE_START       = (state_q == READ);
        REG_READ_Ctrl_1 = use_rs1_q;
        REG_READ_Ctrl_2 = use_rs2_q;
        Reg_Addr_1      = use_rs1_q ? rs1_q : 5'd0;
        Reg_Addr_2      = use_rs2_q ? rs2_q : 5'd0;
      end
      WB: begin
        WRITE_EN       = 1'b1;
        WRITE_Addr     = rd_q;
        REG_WRITE_Ctrl = link_q;
      end
      default: begin
        BUSY = 1'b1;
      end
    endcase
  end

  assign RETIRE_CNT = retire_cnt_q;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sequencer
//   Directed self-checking bench for reg_file_sequencer. Inputs change on
//   the falling clock edge; outputs are sampled there too, i.e. half a cycle
//   after the rising edge that updated the state.
// ---------------------------------------------------------------------------
module tb_reg_file_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [4:0]  RS1, RS2, RD;
  logic        USE_RS1, USE_RS2, USE_RD, LINK;
  logic        EXE_START;
  logic        EXE_DONE;
  logic        REG_READ_Ctrl_1, REG_READ_Ctrl_2;
  logic [4:0]  Reg_Addr_1, Reg_Addr_2;
  logic        WRITE_EN;
  logic [4:0]  WRITE_Addr;
  logic        REG_WRITE_Ctrl;
  logic        BUSY;
  logic [15:0] RETIRE_CNT;

  int n_checks = 0;
  int n_pass   = 0;

  reg_file_sequencer dut (
    .CLK(CLK), .RST(RST),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .RS1(RS1), .RS2(RS2), .RD(RD),
    .USE_RS1(USE_RS1), .USE_RS2(USE_RS2), .USE_RD(USE_RD), .LINK(LINK),
    .EXE_START(EXE_START), .EXE_DONE(EXE_DONE),
    .REG_READ_Ctrl_1(REG_READ_Ctrl_1), .REG_READ_Ctrl_2(REG_READ_Ctrl_2),
    .Reg_Addr_1(Reg_Addr_1), .Reg_Addr_2(Reg_Addr_2),
    .WRITE_EN(WRITE_EN), .WRITE_Addr(WRITE_Addr),
    .REG_WRITE_Ctrl(REG_WRITE_Ctrl),
    .BUSY(BUSY), .RETIRE_CNT(RETIRE_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock: rising edge updates the DUT, falling edge is where
  // the bench samples and drives.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic ud, input logic lnk);
    INSTR_VALID = 1'b1;
    RS1 = rs1; RS2 = rs2; RD = rd;
    USE_RS1 = u1; USE_RS2 = u2; USE_RD = ud; LINK = lnk;
  endtask

  initial begin
    RST = 1'b1;
    INSTR_VALID = 1'b0; EXE_DONE = 1'b0;
    RS1 = 5'd0; RS2 = 5'd0; RD = 5'd0;
    USE_RS1 = 1'b0; USE_RS2 = 1'b0; USE_RD = 1'b0; LINK = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy",   {31'd0, BUSY}, 32'd0);
    check("rst_cnt",    {16'd0, RETIRE_CNT}, 32'd0);
    check("rst_wen",    {31'd0, WRITE_EN}, 32'd0);
    check("rst_start",  {31'd0, EXE_START}, 32'd0);
    check("rst_addr1",  {27'd0, Reg_Addr_1}, 32'd0);
    RST = 1'b0;
    tick();
    check("rel_ready",  {31'd0, INSTR_READY}, 32'd1);

    // ADD x5,x1,x2
    offer(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();                                         // cycle 1: READ
    INSTR_VALID = 1'b0;
    check("add_start",  {31'd0, EXE_START}, 32'd1);
    check("add_ready",  {31'd0, INSTR_READY}, 32'd0);
    check("add_en1",    {31'd0, REG_READ_Ctrl_1}, 32'd1);
    check("add_addr1",  {27'd0, Reg_Addr_1}, 32'd1);
    check("add_addr2",  {27'd0, Reg_Addr_2}, 32'd2);
    tick();                                         // cycle 2: EXEC
    check("add_exec_start", {31'd0, EXE_START}, 32'd0);
    check("add_exec_addr2", {27'd0, Reg_Addr_2}, 32'd2);
    EXE_DONE = 1'b1;
    tick();                                         // cycle 3: WB
    EXE_DONE = 1'b0;
    check("add_wen",    {31'd0, WRITE_EN}, 32'd1);
    check("add_waddr",  {27'd0, WRITE_Addr}, 32'd5);
    check("add_wsel",   {31'd0, REG_WRITE_Ctrl}, 32'd0);
    check("add_wb_en1", {31'd0, REG_READ_Ctrl_1}, 32'd0);
    tick();                                         // cycle 4: IDLE
    check("add_idle",   {31'd0, INSTR_READY}, 32'd1);
    check("add_cnt",    {16'd0, RETIRE_CNT}, 32'd1);
    check("add_wen_off",{31'd0, WRITE_EN}, 32'd0);

    // JAL x1 with stray non-zero rs fields that must not show up
    offer(5'd3, 5'd4, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    INSTR_VALID = 1'b0;
    check("jal_start",  {31'd0, EXE_START}, 32'd1);
    check("jal_en1",    {31'd0, REG_READ_Ctrl_1}, 32'd0);
    check("jal_en2",    {31'd0, REG_READ_Ctrl_2}, 32'd0);
    check("jal_addr1",  {27'd0, Reg_Addr_1}, 32'd0);
    check("jal_addr2",  {27'd0, Reg_Addr_2}, 32'd0);
    tick();
    EXE_DONE = 1'b1;
    tick();
    EXE_DONE = 1'b0;
    check("jal_wen",    {31'd0, WRITE_EN}, 32'd1);
    check("jal_waddr",  {27'd0, WRITE_Addr}, 32'd1);
    check("jal_wsel",   {31'd0, REG_WRITE_Ctrl}, 32'd1);
    tick();
    check("jal_cnt",    {16'd0, RETIRE_CNT}, 32'd2);

    // rd = x0 with a 5-cycle execute: no writeback
    offer(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    INSTR_VALID = 1'b0;
    tick();                                         // EXEC cycle 1
    for (int i = 0; i < 4; i++) begin
      check("x0_exec_busy", {31'd0, BUSY}, 32'd1);
      check("x0_exec_wen",  {31'd0, WRITE_EN}, 32'd0);
      tick();
    end
    check("x0_exec5_addr1", {27'd0, Reg_Addr_1}, 32'd7);
    EXE_DONE = 1'b1;                                // EXEC cycle 5
    tick();
    EXE_DONE = 1'b0;
    check("x0_idle",    {31'd0, INSTR_READY}, 32'd1);
    check("x0_wen",     {31'd0, WRITE_EN}, 32'd0);
    check("x0_cnt",     {16'd0, RETIRE_CNT}, 32'd3);

    // New offer while busy, and EXE_DONE while idle, are both ignored
    offer(5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();                                         // READ
    offer(5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();                                         // EXEC, valid still high
    check("ign_addr1",  {27'd0, Reg_Addr_1}, 32'd10);
    check("ign_addr2",  {27'd0, Reg_Addr_2}, 32'd11);
    tick();                                         // still EXEC
    check("ign_hold",   {31'd0, BUSY}, 32'd1);
    check("ign_addr1b", {27'd0, Reg_Addr_1}, 32'd10);
    EXE_DONE = 1'b1;
    tick();                                         // WB
    INSTR_VALID = 1'b0;
    check("ign_waddr",  {27'd0, WRITE_Addr}, 32'd12);
    check("ign_wsel",   {31'd0, REG_WRITE_Ctrl}, 32'd0);
    tick();                                         // IDLE, EXE_DONE still high
    tick();
    EXE_DONE = 1'b0;
    check("ign_idle",   {31'd0, BUSY}, 32'd0);
    check("ign_cnt",    {16'd0, RETIRE_CNT}, 32'd4);

    // Reset in EXEC aborts the instruction
    offer(5'd1, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    INSTR_VALID = 1'b0;
    tick();                                         // EXEC
    EXE_DONE = 1'b1;
    RST = 1'b1;
    #1;
    check("arst_busy",  {31'd0, BUSY}, 32'd0);
    check("arst_cnt",   {16'd0, RETIRE_CNT}, 32'd0);
    check("arst_wen",   {31'd0, WRITE_EN}, 32'd0);
    tick();
    RST = 1'b0;
    EXE_DONE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("arst_post_wen", {31'd0, WRITE_EN}, 32'd0);
      tick();
    end
    check("arst_ready", {31'd0, INSTR_READY}, 32'd1);
    check("arst_cnt2",  {16'd0, RETIRE_CNT}, 32'd0);

    // Counter wrap: preload 0xFFFE, retire twice
    dut.retire_cnt_q = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      offer(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      INSTR_VALID = 1'b0;
      tick();
      EXE_DONE = 1'b1;
      tick();
      EXE_DONE = 1'b0;
      check("wrap_cnt", {16'd0, RETIRE_CNT}, (i == 0) ? 32'h0000_FFFF : 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of run, expected completion");
    $fatal(1);
  end

endmodule
